// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_pkg;

    localparam int NUM_INPUTS   = 7;
    localparam int NUM_MINTERMS = 128;

    typedef logic [NUM_MINTERMS-1:0] tt_t;
    typedef logic [NUM_INPUTS-1:0]   minterm_t;

    // Sweep sequencing: present minterms, wait out the DUT pipeline, report.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/sweep_delay_line.sv
// Delays the driven minterm index and its valid flag by LATENCY cycles so the
// capture lines up with a pipelined DUT. LATENCY = 0 is a plain wire-through.
module sweep_delay_line
    import truth_table_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  minterm_t in_idx,
    output logic     out_valid,
    output minterm_t out_idx
);

    if (LATENCY == 0) begin : g_wire
        assign out_valid = in_valid;
        assign out_idx   = in_idx;
    end else begin : g_pipe
        logic [LATENCY-1:0] valid_q, valid_d;
        minterm_t           idx_q [LATENCY];
        minterm_t           idx_d [LATENCY];

        // Shift each stage one step toward the output.
        always_comb begin
            valid_d[0] = in_valid;
            idx_d[0]   = in_idx;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                idx_d[i]   = idx_q[i-1];
            end
        end

        // Stage registers; reset flushes every pending capture.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                for (int i = 0; i < LATENCY; i++) idx_q[i] <= '0;
            end else begin
                valid_q <= valid_d;
                for (int i = 0; i < LATENCY; i++) idx_q[i] <= idx_d[i];
            end
        end

        assign out_valid = valid_q[LATENCY-1];
        assign out_idx   = idx_q[LATENCY-1];
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 128 minterms into a 7-input network, captures its output into a
// truth-table signature, counts the ones and compares against a reference.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  tt_t          expected,
    output logic         x0,
    output logic         x1,
    output logic         x2,
    output logic         x3,
    output logic         x4,
    output logic         x5,
    output logic         x6,
    input  logic         out,
    output logic         busy,
    output logic         done,
    output tt_t          tt,
    output logic [7:0]   ones,
    output logic         match,
    output sweep_state_e state_dbg
);

    // Last DRAIN count; DRAIN is only entered when LATENCY > 0.
    localparam logic [2:0] DRAIN_LAST = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

    sweep_state_e state_q, state_d;
    minterm_t     m_q, m_d;
    logic [2:0]   drain_q, drain_d;
    tt_t          exp_q, exp_d;
    tt_t          tt_q, tt_d;
    logic [7:0]   ones_q, ones_d;
    logic         match_q, match_d;

    logic         cap_valid;
    minterm_t     cap_idx;

    // Index/valid of the minterm on x0..x6, realigned to the DUT output.
    sweep_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_q == DRIVE),
        .in_idx    (m_q),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    // Next-state, counter, capture, popcount and compare logic.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        drain_d = drain_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        match_d = match_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    tt_d    = '0;
                    ones_d  = '0;
                    match_d = 1'b0;
                    m_d     = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // The 127 -> 0 wrap leaves x0..x6 at zero after the sweep.
                m_d = m_q + 7'd1;
                if (m_q == 7'd127) begin
                    drain_d = '0;
                    state_d = (LATENCY > 0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DONE;
                else                       drain_d = drain_q + 3'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap_valid) begin
            tt_d[cap_idx] = out;
            if (out) ones_d = ones_q + 8'd1;
        end

        // Compare against the fully captured table as DONE is entered, so
        // the final capture (same edge when LATENCY = 0) is included.
        if (state_d == DONE && state_q != DONE) match_d = (tt_d == exp_q);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            drain_q <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            drain_q <= drain_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            match_q <= match_d;
        end
    end

    assign {x6, x5, x4, x3, x2, x1, x0} = m_q;
    assign busy      = (state_q == DRIVE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign tt        = tt_q;
    assign ones      = ones_q;
    assign match     = match_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: one combinational-DUT instance (LATENCY 0)
// and one instance wrapping a two-register DUT (LATENCY 2).
module tb_truth_table_sweeper;
  import truth_table_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 0: combinational network, LATENCY 0 ----------------
  logic         start0 = 1'b0;
  logic [127:0] exp0 = '0;
  wire  [6:0]   xa;
  logic         out0;
  logic         busy0, done0, match0;
  logic [127:0] tt0;
  logic [7:0]   ones0;
  sweep_state_e st0;
  logic [127:0] func_tt = '0;  // function realised by the network under test

  assign out0 = func_tt[xa];

  truth_table_sweeper #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(exp0),
    .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]), .x4(xa[4]), .x5(xa[5]), .x6(xa[6]),
    .out(out0), .busy(busy0), .done(done0), .tt(tt0), .ones(ones0),
    .match(match0), .state_dbg(st0)
  );

  // ---------------- DUT 2: out = x0 registered twice, LATENCY 2 ----------------
  logic         start2 = 1'b0;
  logic [127:0] exp2 = '0;
  wire  [6:0]   xb;
  logic         p1 = 1'b0, p2 = 1'b0;
  logic         busy2, done2, match2;
  logic [127:0] tt2;
  logic [7:0]   ones2;
  sweep_state_e st2;

  always @(posedge clk) begin
    p1 <= xb[0];
    p2 <= p1;
  end

  truth_table_sweeper #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(exp2),
    .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]), .x4(xb[4]), .x5(xb[5]), .x6(xb[6]),
    .out(p2), .busy(busy2), .done(done2), .tt(tt2), .ones(ones2),
    .match(match2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic maj(logic a, logic b, logic c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // Truth table of each network: bit m = f(minterm m).
  function automatic logic [127:0] build(int mode);
    logic [127:0] t;
    logic [6:0]   m;
    t = '0;
    for (int i = 0; i < 128; i++) begin
      m = 7'(i);
      case (mode)
        0: t[i] = m[0];
        1: t[i] = m[6];
        2: t[i] = maj(maj(m[0], m[1], m[2]), maj(m[0], m[4], m[5]),
                      maj(m[0], m[3], maj(m[1], m[2], m[6])));
        default: t[i] = 1'b1;
      endcase
    end
    return t;
  endfunction

  function automatic logic [7:0] popcnt(logic [127:0] t);
    int n;
    n = 0;
    for (int i = 0; i < 128; i++) n += int'(t[i]);
    return 8'(n);
  endfunction

  // ---------------- driver ----------------
  // Runs one sweep on DUT 0 (which=0) or DUT 2 (which=2) and reports what was
  // observed; done_k is the cycle index of done counting cycle E+1 as 1.
  task automatic sweep(input int which, input logic [127:0] expv, input bit extra,
                       output logic [127:0] tt_o, output logic [7:0] ones_o,
                       output logic match_o, output int done_k, output int busy_n,
                       output bit x_ok, output bit post_ok);
    logic [6:0] xv;
    logic       b, d;
    done_k = -1; busy_n = 0; x_ok = 1'b1; post_ok = 1'b1;
    tt_o = '0; ones_o = '0; match_o = 1'b0;
    @(negedge clk);
    if (which == 0) begin start0 = 1'b1; exp0 = expv; end
    else            begin start2 = 1'b1; exp2 = expv; end
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1 || k == 51) begin start0 = 1'b0; start2 = 1'b0; end
      if (extra && k == 50) begin
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
      end
      xv = (which == 0) ? xa : xb;
      b  = (which == 0) ? busy0 : busy2;
      d  = (which == 0) ? done0 : done2;
      if (b) busy_n++;
      if (k <= 128) begin
        if (xv != 7'(k - 1)) x_ok = 1'b0;
      end else if (xv != 7'd0) x_ok = 1'b0;
      if (d) begin
        done_k  = k;
        tt_o    = (which == 0) ? tt0 : tt2;
        ones_o  = (which == 0) ? ones0 : ones2;
        match_o = (which == 0) ? match0 : match2;
        break;
      end
    end
    if (done_k < 0) begin
      chk("sweep_timeout", 0, 1);
    end else begin
      // A start held through the DONE cycle must not begin a new sweep.
      if (extra) begin
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      b = (which == 0) ? busy0 : busy2;
      d = (which == 0) ? done0 : done2;
      if (b || d) post_ok = 1'b0;
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int           mode;
    logic [127:0] expv;
    logic [127:0] exp_tt;
    logic [7:0]   exp_ones;
    logic         exp_match;
  } vec_t;

  vec_t vecs[3];

  logic [127:0] r_tt, r_exp;
  logic [7:0]   r_ones;
  logic         r_match;
  int           r_done, r_busy;
  bit           r_xok, r_post;

  initial begin
    vecs[0] = '{0, {32{4'hA}}, {32{4'hA}}, 8'd64, 1'b1};
    vecs[1] = '{1, 128'd0, {{64{1'b1}}, {64{1'b0}}}, 8'd64, 1'b0};
    vecs[2] = '{2, 128'hfee8eaa8eaa8e8a8eae8eaa8eaa8e880,
                   128'hfee8eaa8eaa8e8a8eae8eaa8eaa8e880, 8'd0, 1'b1};
    vecs[2].exp_ones = popcnt(vecs[2].exp_tt);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dut0", {tt0, ones0, match0, busy0, done0, xa}, '0);
    chk("reset_dut2", {tt2, ones2, match2, busy2, done2, xb}, '0);
    chk("reset_state", {st0, st2}, {IDLE, IDLE});
    rst = 1'b0;

    // table-driven sweeps on the combinational DUT
    for (int i = 0; i < 3; i++) begin
      func_tt = build(vecs[i].mode);
      sweep(0, vecs[i].expv, 1'b0, r_tt, r_ones, r_match, r_done, r_busy, r_xok, r_post);
      chk($sformatf("vec%0d_tt", i), r_tt, vecs[i].exp_tt);
      chk($sformatf("vec%0d_ones", i), r_ones, vecs[i].exp_ones);
      chk($sformatf("vec%0d_match", i), r_match, vecs[i].exp_match);
      chk($sformatf("vec%0d_done_cycle", i), r_done, 129);
      chk($sformatf("vec%0d_busy_cycles", i), r_busy, 128);
      chk($sformatf("vec%0d_x_seq", i), r_xok, 1);
      chk($sformatf("vec%0d_single_done", i), r_post, 1);
    end

    // pipelined DUT, LATENCY 2
    sweep(2, {32{4'hA}}, 1'b0, r_tt, r_ones, r_match, r_done, r_busy, r_xok, r_post);
    chk("lat2_tt", r_tt, {32{4'hA}});
    chk("lat2_ones", r_ones, 8'd64);
    chk("lat2_match", r_match, 1);
    chk("lat2_done_cycle", r_done, 131);
    chk("lat2_busy_cycles", r_busy, 130);
    chk("lat2_x_seq", r_xok, 1);

    // extra start pulses in DRIVE and DONE
    func_tt = build(0);
    sweep(0, {32{4'hA}}, 1'b1, r_tt, r_ones, r_match, r_done, r_busy, r_xok, r_post);
    chk("extra_start_tt", r_tt, {32{4'hA}});
    chk("extra_start_done_cycle", r_done, 129);
    chk("extra_start_busy_cycles", r_busy, 128);
    chk("extra_start_ignored", r_post, 1);

    // randomized networks against the model
    for (int r = 0; r < 4; r++) begin
      func_tt = {$urandom, $urandom, $urandom, $urandom};
      r_exp   = func_tt;
      if (r % 2 == 1) r_exp[$urandom_range(0, 127)] ^= 1'b1;
      sweep(0, r_exp, 1'b0, r_tt, r_ones, r_match, r_done, r_busy, r_xok, r_post);
      chk($sformatf("rand%0d_tt", r), r_tt, func_tt);
      chk($sformatf("rand%0d_ones", r), r_ones, popcnt(func_tt));
      chk($sformatf("rand%0d_match", r), r_match, r_exp == func_tt);
      chk($sformatf("rand%0d_done_cycle", r), r_done, 129);
    end

    // reset at minterm 50 on both instances
    func_tt = build(0);
    @(negedge clk);
    start0 = 1'b1; start2 = 1'b1; exp0 = '1; exp2 = '1;
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
    for (int k = 0; k < 200 && xa != 7'd50; k++) @(negedge clk);
    chk("rst_reached_m50", {xa, xb}, {7'd50, 7'd50});
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dut0", {tt0, ones0, match0, busy0, done0, xa}, '0);
    chk("midrst_dut2", {tt2, ones2, match2, busy2, done2, xb}, '0);
    chk("midrst_state", {st0, st2}, {IDLE, IDLE});
    rst = 1'b0;
    r_post = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tt0 != '0 || tt2 != '0 || done0 || done2 || busy0 || busy2 || ones2 != '0)
        r_post = 1'b0;
    end
    chk("midrst_no_stale_capture", r_post, 1);

    // fresh sweep with constant out = 1
    func_tt = build(3);
    sweep(0, '1, 1'b0, r_tt, r_ones, r_match, r_done, r_busy, r_xok, r_post);
    chk("const1_tt", r_tt, '1);
    chk("const1_ones", r_ones, 8'd128);
    chk("const1_match", r_match, 1);
    chk("const1_done_cycle", r_done, 129);

    // held outputs after the sweep
    repeat (3) @(negedge clk);
    chk("hold_tt", tt0, '1);
    chk("hold_ones", ones0, 8'd128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
